// File: rtl/ahblite_copy_master_if.sv
// AHB-Lite signal bundle shared by the copy master and whatever slave or
// matrix port it is attached to.
interface ahblite_copy_master_if;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic [2:0]  HSIZE;
    logic [2:0]  HBURST;
    logic [3:0]  HPROT;
    logic        HMASTLOCK;
    logic        HWRITE;
    logic [31:0] HWDATA;
    logic        HREADY;
    logic [31:0] HRDATA;
    logic        HRESP;

    modport master (
        output HADDR, HTRANS, HSIZE, HBURST, HPROT, HMASTLOCK, HWRITE, HWDATA,
        input  HREADY, HRDATA, HRESP
    );

    modport slave (
        input  HADDR, HTRANS, HSIZE, HBURST, HPROT, HMASTLOCK, HWRITE, HWDATA,
        output HREADY, HRDATA, HRESP
    );
endinterface

// File: rtl/ahblite_copy_master.sv
// AHB-Lite master that copies word_count 32-bit words from src_addr to dst_addr
// using single non-pipelined NONSEQ transfers: one read then one write per word.
module ahblite_copy_master #(
    parameter int         CNT_WIDTH = 16,
    parameter logic [3:0] HPROT_VAL = 4'b0011
) (
    input  logic                 HCLK,
    input  logic                 HRESETn,
    input  logic                 start,
    input  logic [31:0]          src_addr,
    input  logic [31:0]          dst_addr,
    input  logic [CNT_WIDTH-1:0] word_count,
    output logic                 busy,
    output logic                 done,
    output logic                 error,
    output logic [2:0]           dbg_state,
    ahblite_copy_master_if.master bus
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RD_A = 3'd1,
        S_RD_D = 3'd2,
        S_WR_A = 3'd3,
        S_WR_D = 3'd4,
        S_FIN  = 3'd5
    } state_e;

    localparam logic [1:0] HT_IDLE   = 2'b00;
    localparam logic [1:0] HT_NONSEQ = 2'b10;

    state_e               state_q, state_d;
    logic [31:0]          src_q, src_d;
    logic [31:0]          dst_q, dst_d;
    logic [CNT_WIDTH-1:0] rem_q, rem_d;
    logic [31:0]          buf_q, buf_d;
    logic [31:0]          haddr_q, haddr_d;
    logic [1:0]           htrans_q, htrans_d;
    logic                 hwrite_q, hwrite_d;
    logic [31:0]          hwdata_q, hwdata_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 error_q, error_d;

    // Byte-lane bits of the start addresses are deliberately discarded.
    logic unused_addr_lsbs;
    assign unused_addr_lsbs = ^{src_addr[1:0], dst_addr[1:0]};

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q  <= S_IDLE;
            src_q    <= '0;
            dst_q    <= '0;
            rem_q    <= '0;
            buf_q    <= '0;
            haddr_q  <= '0;
            htrans_q <= HT_IDLE;
            hwrite_q <= 1'b0;
            hwdata_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            error_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            src_q    <= src_d;
            dst_q    <= dst_d;
            rem_q    <= rem_d;
            buf_q    <= buf_d;
            haddr_q  <= haddr_d;
            htrans_q <= htrans_d;
            hwrite_q <= hwrite_d;
            hwdata_q <= hwdata_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            error_q  <= error_d;
        end
    end

    // Bus outputs are registered from the next state, so each state's bus
    // signals are visible for exactly the cycles spent in that state.
    always_comb begin
        state_d  = state_q;
        src_d    = src_q;
        dst_d    = dst_q;
        rem_d    = rem_q;
        buf_d    = buf_q;
        haddr_d  = haddr_q;
        htrans_d = htrans_q;
        hwrite_d = hwrite_q;
        hwdata_d = hwdata_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        error_d  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (word_count != '0) begin
                        src_d    = {src_addr[31:2], 2'b00};
                        dst_d    = {dst_addr[31:2], 2'b00};
                        rem_d    = word_count;
                        state_d  = S_RD_A;
                        haddr_d  = {src_addr[31:2], 2'b00};
                        htrans_d = HT_NONSEQ;
                        hwrite_d = 1'b0;
                        busy_d   = 1'b1;
                    end else begin
                        state_d = S_FIN;
                        done_d  = 1'b1;
                    end
                end
            end
            S_RD_A: begin
                if (bus.HREADY) begin
                    state_d  = S_RD_D;
                    htrans_d = HT_IDLE;
                end
            end
            S_RD_D: begin
                if (bus.HREADY) begin
                    if (bus.HRESP) begin
                        state_d  = S_IDLE;
                        hwrite_d = 1'b0;
                        busy_d   = 1'b0;
                        error_d  = 1'b1;
                    end else begin
                        buf_d    = bus.HRDATA;
                        state_d  = S_WR_A;
                        haddr_d  = dst_q;
                        htrans_d = HT_NONSEQ;
                        hwrite_d = 1'b1;
                    end
                end
            end
            S_WR_A: begin
                if (bus.HREADY) begin
                    state_d  = S_WR_D;
                    htrans_d = HT_IDLE;
                    hwdata_d = buf_q;
                end
            end
            S_WR_D: begin
                if (bus.HREADY) begin
                    if (bus.HRESP) begin
                        state_d  = S_IDLE;
                        hwrite_d = 1'b0;
                        busy_d   = 1'b0;
                        error_d  = 1'b1;
                    end else begin
                        src_d = src_q + 32'd4;
                        dst_d = dst_q + 32'd4;
                        rem_d = rem_q - CNT_WIDTH'(1);
                        if (rem_q == CNT_WIDTH'(1)) begin
                            state_d  = S_FIN;
                            hwrite_d = 1'b0;
                            busy_d   = 1'b0;
                            done_d   = 1'b1;
                        end else begin
                            state_d  = S_RD_A;
                            haddr_d  = src_q + 32'd4;
                            htrans_d = HT_NONSEQ;
                            hwrite_d = 1'b0;
                        end
                    end
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d  = S_IDLE;
                htrans_d = HT_IDLE;
                busy_d   = 1'b0;
            end
        endcase
    end

    assign bus.HADDR     = haddr_q;
    assign bus.HTRANS    = htrans_q;
    assign bus.HSIZE     = 3'b010;
    assign bus.HBURST    = 3'b000;
    assign bus.HPROT     = HPROT_VAL;
    assign bus.HMASTLOCK = 1'b0;
    assign bus.HWRITE    = hwrite_q;
    assign bus.HWDATA    = hwdata_q;

    assign busy      = busy_q;
    assign done      = done_q;
    assign error     = error_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_ahblite_copy_master.sv
// Directed bench for ahblite_copy_master: RAM slave model with wait-state,
// address-stall and error-response knobs, bus transfer log and cycle timing.
module tb_ahblite_copy_master;

  logic        HCLK;
  logic        HRESETn;
  logic        start;
  logic [31:0] src_addr;
  logic [31:0] dst_addr;
  logic [15:0] word_count;
  logic        busy;
  logic        done;
  logic        error;
  logic [2:0]  dbg_state;

  ahblite_copy_master_if bus();

  ahblite_copy_master #(.CNT_WIDTH(16), .HPROT_VAL(4'b0011)) dut (
    .HCLK       (HCLK),
    .HRESETn    (HRESETn),
    .start      (start),
    .src_addr   (src_addr),
    .dst_addr   (dst_addr),
    .word_count (word_count),
    .busy       (busy),
    .done       (done),
    .error      (error),
    .dbg_state  (dbg_state),
    .bus        (bus)
  );

  // ---------------- clock ----------------
  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  int cyc = 0;
  always @(posedge HCLK) cyc <= cyc + 1;

  // ---------------- slave model ----------------
  logic [31:0] mem [0:1023];
  logic        mem_init = 1'b0;
  int          wait_cfg = 0;
  int          fs_cfg   = 0;
  logic        err_en   = 1'b0;
  logic [31:0] err_addr = 32'h0;

  logic        dp_valid, dp_write, dp_err, err_stage;
  logic [31:0] dp_addr;
  int          dp_wait, fs_cnt;
  logic        s_ready, s_resp, bus_ready;

  always_comb begin
    s_ready = 1'b1;
    s_resp  = 1'b0;
    if (dp_valid) begin
      if (dp_err) begin
        s_resp  = 1'b1;
        s_ready = err_stage;
      end else begin
        s_ready = (dp_wait == 0);
      end
    end
    bus_ready = s_ready && !(bus.HTRANS[1] && (fs_cnt < fs_cfg));
  end

  assign bus.HREADY = bus_ready;
  assign bus.HRESP  = s_resp;
  assign bus.HRDATA = mem[dp_addr[11:2]];

  always @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      dp_valid  <= 1'b0;
      dp_write  <= 1'b0;
      dp_err    <= 1'b0;
      err_stage <= 1'b0;
      dp_addr   <= 32'h0;
      dp_wait   <= 0;
      fs_cnt    <= 0;
    end else if (mem_init) begin
      for (int i = 0; i < 1024; i++) mem[i] <= 32'hA5A50000 | i;
      mem[64] <= 32'h11111111;
      mem[65] <= 32'h22222222;
      mem[66] <= 32'h33333333;
      mem[67] <= 32'h44444444;
    end else begin
      if (dp_valid && !s_ready) begin
        if (dp_err) err_stage <= 1'b1;
        else        dp_wait   <= dp_wait - 1;
      end
      if (bus.HTRANS[1] && !bus_ready) fs_cnt <= fs_cnt + 1;
      if (bus_ready) begin
        if (dp_valid && dp_write && !dp_err) mem[dp_addr[11:2]] <= bus.HWDATA;
        dp_valid  <= bus.HTRANS[1];
        dp_addr   <= bus.HADDR;
        dp_write  <= bus.HWRITE;
        dp_wait   <= wait_cfg;
        dp_err    <= err_en && bus.HTRANS[1] && !bus.HWRITE && (bus.HADDR == err_addr);
        err_stage <= 1'b0;
        fs_cnt    <= 0;
      end
    end
  end

  // ---------------- bus monitor ----------------
  logic        mon_clr = 1'b0;
  logic [32:0] bus_log [$];
  int          first_ns, ns_cnt, done_cnt, done_cyc, err_cnt, busy_cnt;
  int          stab_err, addr_stalls, wd_stalls;
  logic        p_ns_stall, p_wd_stall, p_hwrite;
  logic [1:0]  p_htrans;
  logic [31:0] p_haddr, p_hwdata;

  always @(negedge HCLK) begin
    if (mon_clr) begin
      bus_log.delete();
      first_ns <= -1; ns_cnt <= 0; done_cnt <= 0; done_cyc <= -1;
      err_cnt <= 0; busy_cnt <= 0; stab_err <= 0; addr_stalls <= 0; wd_stalls <= 0;
      p_ns_stall <= 1'b0; p_wd_stall <= 1'b0;
    end else if (HRESETn) begin
      if (bus.HTRANS == 2'b10) begin
        if (first_ns < 0) first_ns <= cyc;
        ns_cnt <= ns_cnt + 1;
        if (bus.HREADY) bus_log.push_back({bus.HWRITE, bus.HADDR});
        else            addr_stalls <= addr_stalls + 1;
      end
      if (dp_valid && dp_write && !bus.HREADY) wd_stalls <= wd_stalls + 1;
      if (done)  begin done_cnt <= done_cnt + 1; done_cyc <= cyc; end
      if (error) err_cnt <= err_cnt + 1;
      if (busy)  busy_cnt <= busy_cnt + 1;
      // Stalled address phase must hold, stalled write data phase must hold HWDATA.
      if (p_ns_stall && (bus.HTRANS != p_htrans || bus.HADDR != p_haddr || bus.HWRITE != p_hwrite))
        stab_err <= stab_err + 1;
      if (p_wd_stall && bus.HWDATA != p_hwdata) stab_err <= stab_err + 1;
      p_ns_stall <= (bus.HTRANS == 2'b10) && !bus.HREADY;
      p_wd_stall <= dp_valid && dp_write && !bus.HREADY;
    end
    p_htrans <= bus.HTRANS;
    p_haddr  <= bus.HADDR;
    p_hwrite <= bus.HWRITE;
    p_hwdata <= bus.HWDATA;
  end

  // ---------------- scoreboard ----------------
  int          errors = 0;
  int          checks = 0;
  logic [32:0] exp_q [$];
  int          start_cyc;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_log(input string tag);
    check({tag, "_log_len"}, bus_log.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < bus_log.size()) check($sformatf("%s_log%0d", tag, i), bus_log[i], exp_q[i]);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge HCLK);
    #2;
  endtask

  task automatic clear_mon();
    tick(); mon_clr = 1'b1;
    tick(); mon_clr = 1'b0;
  endtask

  task automatic load_mem();
    tick(); mem_init = 1'b1;
    tick(); mem_init = 1'b0;
  endtask

  task automatic do_start(input logic [31:0] s, input logic [31:0] d, input logic [15:0] n);
    tick();
    start = 1'b1; src_addr = s; dst_addr = d; word_count = n;
    start_cyc = cyc;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_end(input string tag, input int budget);
    int n = 0;
    while (!(done || error) && n < budget) begin
      @(negedge HCLK); #1;
      n++;
    end
    check({tag, "_timeout"}, (n < budget), 1);
    repeat (3) tick();
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    HRESETn = 1'b0; start = 1'b0; src_addr = '0; dst_addr = '0; word_count = '0;
    repeat (3) tick();
    check("rst_htrans", bus.HTRANS, 2'b00);
    check("rst_haddr", bus.HADDR, 32'h0);
    check("rst_hwrite", bus.HWRITE, 1'b0);
    check("rst_hwdata", bus.HWDATA, 32'h0);
    check("rst_flags", {busy, done, error}, 3'b000);
    check("rst_state", dbg_state, 3'd0);
    check("const_hsize", bus.HSIZE, 3'b010);
    check("const_hburst", bus.HBURST, 3'b000);
    check("const_hprot", bus.HPROT, 4'b0011);
    check("const_lock", bus.HMASTLOCK, 1'b0);
    HRESETn = 1'b1;
    load_mem();

    // 1: zero-wait copy of 3 words, 0x100 -> 0x200
    clear_mon();
    do_start(32'h100, 32'h200, 16'd3);
    wait_end("t1", 200);
    exp_q = '{{1'b0, 32'h100}, {1'b1, 32'h200}, {1'b0, 32'h104},
              {1'b1, 32'h204}, {1'b0, 32'h108}, {1'b1, 32'h208}};
    check_log("t1");
    check("t1_first_ns_lat", first_ns - start_cyc, 1);
    // done lands in the 13th cycle counting the first NONSEQ cycle as cycle 1
    check("t1_done_span", done_cyc - first_ns + 1, 13);
    check("t1_done_cnt", done_cnt, 1);
    check("t1_err_cnt", err_cnt, 0);
    check("t1_busy_cycles", busy_cnt, 12);
    check("t1_busy_after", busy, 1'b0);
    check("t1_mem200", mem[128], 32'h11111111);
    check("t1_mem204", mem[129], 32'h22222222);
    check("t1_mem208", mem[130], 32'h33333333);
    check("t1_mem20c", mem[131], 32'hA5A50083);

    // 2: two wait states per data phase and two stall cycles per address phase
    load_mem();
    wait_cfg = 2; fs_cfg = 2;
    clear_mon();
    do_start(32'h100, 32'h300, 16'd2);
    wait_end("t2", 300);
    exp_q = '{{1'b0, 32'h100}, {1'b1, 32'h300}, {1'b0, 32'h104}, {1'b1, 32'h304}};
    check_log("t2");
    check("t2_stability", stab_err, 0);
    check("t2_addr_stalls", addr_stalls, 8);
    check("t2_wdata_stalls", wd_stalls, 4);
    check("t2_mem300", mem[192], 32'h11111111);
    check("t2_mem304", mem[193], 32'h22222222);
    check("t2_mem308", mem[194], 32'hA5A500C2);
    check("t2_done_cnt", done_cnt, 1);

    // 2b: one wait state per data phase -> 6 cycles per word
    wait_cfg = 1; fs_cfg = 0;
    clear_mon();
    do_start(32'h100, 32'h300, 16'd2);
    wait_end("t2b", 200);
    check("t2b_done_span", done_cyc - first_ns + 1, 13);
    wait_cfg = 0;

    // 3: zero count -> done only, no bus activity
    clear_mon();
    do_start(32'h100, 32'h200, 16'd0);
    wait_end("t3", 50);
    repeat (3) tick();
    check("t3_ns_cycles", ns_cnt, 0);
    check("t3_done_cnt", done_cnt, 1);
    check("t3_done_lat", done_cyc - start_cyc, 1);
    check("t3_err_cnt", err_cnt, 0);
    check("t3_busy_cycles", busy_cnt, 0);

    // 4: two-cycle ERROR on the second read of a 4-word copy
    load_mem();
    err_en = 1'b1; err_addr = 32'h104;
    clear_mon();
    do_start(32'h100, 32'h200, 16'd4);
    wait_end("t4", 200);
    repeat (5) tick();
    exp_q = '{{1'b0, 32'h100}, {1'b1, 32'h200}, {1'b0, 32'h104}};
    check_log("t4");
    check("t4_err_cnt", err_cnt, 1);
    check("t4_done_cnt", done_cnt, 0);
    check("t4_busy_after", busy, 1'b0);
    check("t4_mem200", mem[128], 32'h11111111);
    check("t4_mem204", mem[129], 32'hA5A50081);
    err_en = 1'b0;

    // 5: unaligned src, second start while busy must be ignored
    load_mem();
    clear_mon();
    do_start(32'h103, 32'h400, 16'd2);
    repeat (3) tick();
    start = 1'b1; src_addr = 32'h180; dst_addr = 32'h500; word_count = 16'd5;
    tick();
    start = 1'b0;
    wait_end("t5", 200);
    exp_q = '{{1'b0, 32'h100}, {1'b1, 32'h400}, {1'b0, 32'h104}, {1'b1, 32'h404}};
    check_log("t5");
    check("t5_done_cnt", done_cnt, 1);
    check("t5_mem400", mem[256], 32'h11111111);
    check("t5_mem404", mem[257], 32'h22222222);
    check("t5_mem500", mem[320], 32'hA5A50140);

    // 6: reset asserted during a write address phase, then a clean copy
    load_mem();
    clear_mon();
    do_start(32'h100, 32'h600, 16'd3);
    begin
      int n = 0;
      while (dbg_state != 3'd3 && n < 50) begin
        @(negedge HCLK); #1;
        n++;
      end
      check("t6_reach_wr_a", n < 50, 1);
    end
    HRESETn = 1'b0;
    #1;
    check("t6_rst_htrans", bus.HTRANS, 2'b00);
    check("t6_rst_haddr", bus.HADDR, 32'h0);
    check("t6_rst_flags", {busy, done, error}, 3'b000);
    repeat (2) tick();
    HRESETn = 1'b1;
    load_mem();
    clear_mon();
    do_start(32'h100, 32'h600, 16'd3);
    wait_end("t6", 200);
    exp_q = '{{1'b0, 32'h100}, {1'b1, 32'h600}, {1'b0, 32'h104},
              {1'b1, 32'h604}, {1'b0, 32'h108}, {1'b1, 32'h608}};
    check_log("t6");
    check("t6_done_cnt", done_cnt, 1);
    check("t6_err_cnt", err_cnt, 0);
    check("t6_mem600", mem[384], 32'h11111111);
    check("t6_mem604", mem[385], 32'h22222222);
    check("t6_mem608", mem[386], 32'h33333333);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
